// File: rtl/uart_alu_host.sv
// -----------------------------------------------------------------------------
// uart_alu_host
//
// Host-side initiator for the UART ALU loopback test circuit. Sends a 3-byte
// command frame ({HDR,op}, a, b) through a byte-level uart_tx handshake, then
// waits (bounded by TIMEOUT_CYCLES) for the single result byte from uart_rx and
// compares it against the caller-supplied expected value.
//
// Handshake: a byte moves on every cycle where tx_valid && tx_ready are both
// high. Once raised, tx_valid stays high and tx_data stays stable until that
// transfer happens. rx_valid is a one-cycle strobe qualifying rx_data.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, accepted only in IDLE
//   op, a, b, expected  command fields and expected result (latched on start)
//   tx_data, tx_valid   byte stream towards uart_tx
//   tx_ready            uart_tx accepts a byte this cycle
//   rx_data, rx_valid   response byte from uart_rx
//   busy                high from the cycle after start accept until DONE exits
//   done                one-cycle completion pulse
//   pass, timeout       outcome, held until the next accepted start
//   result              received byte (0 on timeout)
//   pass_count,
//   fail_count          transaction statistics (0 unless UART_HOST_STATS_EN)
//   dbg_state           current FSM state, for debug and checkers
//
// Build option: define UART_HOST_STATS_EN to enable the saturating
// pass/fail transaction counters.
// -----------------------------------------------------------------------------
module uart_alu_host #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [3:0] HDR            = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  expected,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  result,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic [2:0]  dbg_state
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND_OP  = 3'd1;
    localparam logic [2:0] S_SEND_A   = 3'd2;
    localparam logic [2:0] S_SEND_B   = 3'd3;
    localparam logic [2:0] S_WAIT_RSP = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]    state;
    logic [3:0]    op_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [7:0]    exp_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            exp_q   <= '0;
            cnt     <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        exp_q   <= expected;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        result  <= '0;
                        state   <= S_SEND_OP;
                    end
                end
                S_SEND_OP: if (tx_ready) state <= S_SEND_A;
                S_SEND_A:  if (tx_ready) state <= S_SEND_B;
                S_SEND_B: begin
                    if (tx_ready) begin
                        cnt   <= '0;
                        state <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    // A response arriving on the expiry cycle takes priority.
                    if (rx_valid) begin
                        result <= rx_data;
                        pass   <= (rx_data == exp_q);
                        state  <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        result  <= '0;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            S_SEND_OP: begin tx_valid = 1'b1; tx_data = {HDR, op_q}; end
            S_SEND_A:  begin tx_valid = 1'b1; tx_data = a_q;         end
            S_SEND_B:  begin tx_valid = 1'b1; tx_data = b_q;         end
            default:   begin tx_valid = 1'b0; tx_data = 8'h00;       end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

`ifdef UART_HOST_STATS_EN
    // pass is already final while in DONE, so count on the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (state == S_DONE) begin
            if (pass) begin
                if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            end else begin
                if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            end
        end
    end
`else
    assign pass_count = 16'h0000;
    assign fail_count = 16'h0000;
`endif

endmodule
